ann_mac_pipe: RTL and testbench
===============================

# ann_mac_pipe

Parametrised, pipelined multiply-accumulate unit for ANN neuron evaluation: unsigned activation × signed weight, optional accumulation over a beat sequence, narrowed to the output width with selectable saturation. It replaces the fixed-width single-cycle multiplier cores in the ANN datapath, adding valid/ready flow control, configurable pipeline depth and overflow reporting. It sits between the weight/activation fetch logic and the activation-function stage.

## Interface
- DIN0_WIDTH, 7: unsigned activation operand width (1..24)
- DIN1_WIDTH, 14: signed weight operand width (2..24)
- DOUT_WIDTH, 14: signed result width (2..ACC_WIDTH)
- ACC_WIDTH, 32: signed accumulator width (≥ DIN0_WIDTH+DIN1_WIDTH)
- NUM_STAGE, 3: total latency in enabled clock edges (≥ 2)
- SAT_EN, 1: 1 = saturate on narrowing, 0 = truncate to low DOUT_WIDTH bits
- ap_clk  in  1  clock, rising edge
- ap_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  unit can accept a beat
- din0  in  DIN0_WIDTH  unsigned activation
- din1  in  DIN1_WIDTH  signed weight
- in_last  in  1  final beat of an accumulation sequence
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- dout  out  DOUT_WIDTH  signed narrowed result
- dout_ovf  out  1  narrowing overflow flag for this result

## Operation
- Beat accepted when in_valid && in_ready on a rising edge.
- Product = signed({1'b0,din0}) × signed(din1), full width DIN0_WIDTH+DIN1_WIDTH, sign-extended to ACC_WIDTH.
- Accumulator stage: sum = acc + product. Non-last beat: acc ← sum, no output. Last beat: output register ← narrow(sum), acc ← 0.
- Single-beat sequences (in_last=1 every beat) give a plain pipelined multiplier.
- Narrowing: if sum in [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1], dout = sum, dout_ovf = 0. Otherwise dout_ovf = 1 and dout = clamp to nearest bound (SAT_EN=1) or sum[DOUT_WIDTH-1:0] (SAT_EN=0).
- Accumulator wraps two's-complement at ACC_WIDTH; no flag. Sizing ACC_WIDTH for sequence length is the integrator's responsibility.
- Reset: all stage valids 0, acc 0, out_valid 0, dout 0, dout_ovf 0. Reset mid-sequence discards the partial sum and all in-flight beats.

## Timing
- Global enable ce = !out_valid || out_ready; in_ready = ce (combinational, no dependence on in_valid).
- All pipeline registers and acc advance only when ce = 1; with ce = 0 every stage, acc, dout and dout_ovf hold.
- Latency: last beat accepted on edge t → out_valid high after edge t+NUM_STAGE-1 (accept edge counts as stage 1), given ce = 1 throughout.
- Throughput: one beat per cycle; back-to-back last beats give one result per cycle with out_ready = 1.
- out_valid && !out_ready: dout/dout_ovf stable until handshake; no result lost or duplicated.
- Result handshake and new-result arrival on the same edge: new result replaces old, out_valid stays 1.

## Structure
- Package ann_mac_pkg: narrowing function (sat/truncate plus ovf), clog2 helper, parameter range checks.
- Sub-module ann_mac_mul_pipe: operand register + multiplier + NUM_STAGE-2 product registers with valid/last sideband, ce-gated; structured for DSP inference/retiming. Top holds accumulator, narrowing and output register.

## Test plan
- Single beat din0=100, din1=-50, last, NUM_STAGE=3 -> dout=-5000, dout_ovf=0, out_valid 2 edges after accept edge.
- din0=127, din1=8191, last -> SAT_EN=1: dout=8191, dout_ovf=1; SAT_EN=0: dout=8065, dout_ovf=1.
- Sequence (10,3),(20,-4),(5,100),(1,-1,last) -> exactly one result, dout=449; next sequence starts from acc=0.
- Pipeline full, out_ready low 5 cycles -> in_ready low, dout held, all results delivered in order once out_ready returns.
- Two non-last beats, ap_rst_n pulsed low asynchronously mid-cycle, then (2,3,last) -> all outputs 0 during reset, then dout=6.
- Ten back-to-back last beats with out_ready=1 -> ten results on ten consecutive cycles, correct products.

Source files
------------

// File: rtl/ann_mac_pkg.sv
// Shared types and helpers for the ANN multiply-accumulate pipeline:
// result narrowing with saturate/truncate, a clog2 helper, and parameter range checks.
package ann_mac_pkg;

    localparam int unsigned MAX_W = 64;

    typedef struct packed {
        logic [MAX_W-1:0] val;
        logic             ovf;
    } narrow_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    // Only the low dw bits of val are meaningful; the truncate case relies on that.
    function automatic narrow_t narrow(input logic signed [MAX_W-1:0] sum,
                                       input int unsigned dw,
                                       input bit sat);
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        narrow_t r;
        hi    = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo    = -(64'sd1 <<< (dw - 1));
        r.val = sum;
        r.ovf = 1'b0;
        if (sum > hi) begin
            r.ovf = 1'b1;
            if (sat) r.val = hi;
        end else if (sum < lo) begin
            r.ovf = 1'b1;
            if (sat) r.val = lo;
        end
        return r;
    endfunction

    function automatic bit params_ok(input int unsigned d0, input int unsigned d1,
                                     input int unsigned dout, input int unsigned acc,
                                     input int unsigned ns);
        return (d0 >= 1) && (d0 <= 24) && (d1 >= 2) && (d1 <= 24) &&
               (dout >= 2) && (dout <= acc) && (acc >= d0 + d1) &&
               (acc <= MAX_W) && (ns >= 2);
    endfunction

endpackage

// File: rtl/ann_mac_pipe_if.sv
// Beat-in / result-out handshake bundle for ann_mac_pipe.
interface ann_mac_pipe_if #(
    parameter int unsigned DIN0_WIDTH = 7,
    parameter int unsigned DIN1_WIDTH = 14,
    parameter int unsigned DOUT_WIDTH = 14
);
    logic                         in_valid;
    logic                         in_ready;
    logic [DIN0_WIDTH-1:0]        din0;
    logic signed [DIN1_WIDTH-1:0] din1;
    logic                         in_last;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DOUT_WIDTH-1:0] dout;
    logic                         dout_ovf;

    modport master (
        output in_valid, din0, din1, in_last, out_ready,
        input  in_ready, out_valid, dout, dout_ovf
    );

    modport slave (
        input  in_valid, din0, din1, in_last, out_ready,
        output in_ready, out_valid, dout, dout_ovf
    );
endinterface

// File: rtl/ann_mac_mul_pipe.sv
// Operand register, unsigned x signed multiplier and NUM_STAGE-2 product registers,
// all advancing on ce; valid/last travel alongside the product.
module ann_mac_mul_pipe #(
    parameter int unsigned DIN0_WIDTH = 7,
    parameter int unsigned DIN1_WIDTH = 14,
    parameter int unsigned NUM_STAGE  = 3
) (
    input  logic                                  ap_clk,
    input  logic                                  ap_rst_n,
    input  logic                                  ce,
    input  logic                                  in_valid,
    input  logic [DIN0_WIDTH-1:0]                 din0,
    input  logic signed [DIN1_WIDTH-1:0]          din1,
    input  logic                                  in_last,
    output logic                                  out_valid,
    output logic                                  out_last,
    output logic signed [DIN0_WIDTH+DIN1_WIDTH-1:0] out_prod
);
    localparam int unsigned PW = DIN0_WIDTH + DIN1_WIDTH;
    localparam int unsigned D  = NUM_STAGE - 2;

    logic [DIN0_WIDTH-1:0]        a_q, a_d;
    logic signed [DIN1_WIDTH-1:0] b_q, b_d;
    logic                         v_q, v_d, l_q, l_d;
    logic signed [PW-1:0]         a_ext, b_ext, prod;

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        v_d = v_q;
        l_d = l_q;
        if (ce) begin
            a_d = din0;
            b_d = din1;
            v_d = in_valid;
            l_d = in_last;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            a_q <= '0;
            b_q <= '0;
            v_q <= 1'b0;
            l_q <= 1'b0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            v_q <= v_d;
            l_q <= l_d;
        end
    end

    // Zero-extended activation makes the signed product exact in PW bits.
    assign a_ext = PW'($signed({1'b0, a_q}));
    assign b_ext = PW'(b_q);
    assign prod  = a_ext * b_ext;

    if (D == 0) begin : g_no_preg
        assign out_prod  = prod;
        assign out_valid = v_q;
        assign out_last  = l_q;
    end else begin : g_preg
        logic signed [PW-1:0] p_q [D];
        logic signed [PW-1:0] p_d [D];
        logic [D-1:0]         pv_q, pv_d, pl_q, pl_d;

        always_comb begin
            p_d  = p_q;
            pv_d = pv_q;
            pl_d = pl_q;
            if (ce) begin
                p_d[0]  = prod;
                pv_d[0] = v_q;
                pl_d[0] = l_q;
                for (int unsigned i = 1; i < D; i++) begin
                    p_d[i]  = p_q[i-1];
                    pv_d[i] = pv_q[i-1];
                    pl_d[i] = pl_q[i-1];
                end
            end
        end

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                p_q  <= '{default: '0};
                pv_q <= '0;
                pl_q <= '0;
            end else begin
                p_q  <= p_d;
                pv_q <= pv_d;
                pl_q <= pl_d;
            end
        end

        assign out_prod  = p_q[D-1];
        assign out_valid = pv_q[D-1];
        assign out_last  = pl_q[D-1];
    end
endmodule

// File: rtl/ann_mac_pipe.sv
// Pipelined ANN multiply-accumulate: product pipe, beat-sequence accumulator,
// narrowing to DOUT_WIDTH with optional saturation, and a ce-stalled output register.
module ann_mac_pipe
    import ann_mac_pkg::*;
#(
    parameter int unsigned DIN0_WIDTH = 7,
    parameter int unsigned DIN1_WIDTH = 14,
    parameter int unsigned DOUT_WIDTH = 14,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned NUM_STAGE  = 3,
    parameter int unsigned SAT_EN     = 1
) (
    input  logic           ap_clk,
    input  logic           ap_rst_n,
    ann_mac_pipe_if.slave  bus
);
    localparam int unsigned PW = DIN0_WIDTH + DIN1_WIDTH;

    if (!params_ok(DIN0_WIDTH, DIN1_WIDTH, DOUT_WIDTH, ACC_WIDTH, NUM_STAGE)) begin : g_param_err
        $error("ann_mac_pipe: parameter out of range");
    end

    logic                         ce;
    logic                         mul_valid, mul_last;
    logic signed [PW-1:0]         mul_prod;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, sum;
    logic                         out_valid_q, out_valid_d;
    logic signed [DOUT_WIDTH-1:0] dout_q, dout_d;
    logic                         ovf_q, ovf_d;
    narrow_t                      nr;
    logic                         unused_narrow;

    assign ce           = !out_valid_q || bus.out_ready;
    assign bus.in_ready = ce;

    ann_mac_mul_pipe #(
        .DIN0_WIDTH (DIN0_WIDTH),
        .DIN1_WIDTH (DIN1_WIDTH),
        .NUM_STAGE  (NUM_STAGE)
    ) u_mul (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .ce        (ce),
        .in_valid  (bus.in_valid),
        .din0      (bus.din0),
        .din1      (bus.din1),
        .in_last   (bus.in_last),
        .out_valid (mul_valid),
        .out_last  (mul_last),
        .out_prod  (mul_prod)
    );

    // While ce is high the held result is either absent or being taken, so the
    // next out_valid is exactly "a last beat arrives now".
    always_comb begin
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        ovf_d       = ovf_q;
        sum         = acc_q + ACC_WIDTH'(mul_prod);
        nr          = narrow(MAX_W'(sum), DOUT_WIDTH, SAT_EN != 0);
        if (ce) begin
            out_valid_d = mul_valid && mul_last;
            if (mul_valid) begin
                if (mul_last) begin
                    acc_d  = '0;
                    dout_d = nr.val[DOUT_WIDTH-1:0];
                    ovf_d  = nr.ovf;
                end else begin
                    acc_d = sum;
                end
            end
        end
    end

    assign unused_narrow = ^(nr.val >> DOUT_WIDTH);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.dout_ovf  = ovf_q;
endmodule

// File: tb/tb_ann_mac_pipe.sv
// Directed bench for ann_mac_pipe: one saturating and one truncating instance
// share the same stimulus; expected values are hand-computed constants.
module tb_ann_mac_pipe;

    logic ap_clk;
    logic ap_rst_n;
    int   checks;
    int   errors;

    ann_mac_pipe_if #(.DIN0_WIDTH(7), .DIN1_WIDTH(14), .DOUT_WIDTH(14)) bus ();
    ann_mac_pipe_if #(.DIN0_WIDTH(7), .DIN1_WIDTH(14), .DOUT_WIDTH(14)) bus_t ();

    assign bus_t.in_valid  = bus.in_valid;
    assign bus_t.din0      = bus.din0;
    assign bus_t.din1      = bus.din1;
    assign bus_t.in_last   = bus.in_last;
    assign bus_t.out_ready = bus.out_ready;

    ann_mac_pipe #(
        .DIN0_WIDTH(7), .DIN1_WIDTH(14), .DOUT_WIDTH(14),
        .ACC_WIDTH(32), .NUM_STAGE(3), .SAT_EN(1)
    ) u_dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    ann_mac_pipe #(
        .DIN0_WIDTH(7), .DIN1_WIDTH(14), .DOUT_WIDTH(14),
        .ACC_WIDTH(32), .NUM_STAGE(3), .SAT_EN(0)
    ) u_dut_trunc (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus_t)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic drive(input int a, input int b, input bit last);
        bus.in_valid = 1'b1;
        bus.din0     = 7'(a);
        bus.din1     = 14'(b);
        bus.in_last  = last;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.din0     = '0;
        bus.din1     = '0;
        bus.in_last  = 1'b0;
    endtask

    int bnd_a   [4] = '{1, 1, 64, 127};
    int bnd_b   [4] = '{8191, -8192, 128, -8192};
    int bnd_sat [4] = '{8191, -8192, 8191, -8192};
    int bnd_trc [4] = '{8191, -8192, -8192, -8192};
    int bnd_ovf [4] = '{0, 0, 1, 1};

    initial begin
        checks       = 0;
        errors       = 0;
        bus.out_ready = 1'b1;
        idle();
        ap_rst_n = 1'b1;
        #1 ap_rst_n = 1'b0;
        #2;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_dout", $signed(bus.dout), 0);
        chk("rst_ovf", bus.dout_ovf, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        tick();
        tick();
        ap_rst_n = 1'b1;
        tick();

        // Single beat latency
        drive(100, -50, 1'b1);
        tick();
        idle();
        chk("lat_e0_valid", bus.out_valid, 0);
        tick();
        chk("lat_e1_valid", bus.out_valid, 0);
        tick();
        chk("lat_e2_valid", bus.out_valid, 1);
        chk("mul_dout", $signed(bus.dout), -5000);
        chk("mul_ovf", bus.dout_ovf, 0);
        tick();
        chk("mul_consumed", bus.out_valid, 0);

        // Positive overflow: saturate vs truncate
        drive(127, 8191, 1'b1);
        tick();
        idle();
        tick();
        tick();
        chk("ovf_valid", bus.out_valid, 1);
        chk("sat_dout", $signed(bus.dout), 8191);
        chk("sat_ovf", bus.dout_ovf, 1);
        chk("trc_dout", $signed(bus_t.dout), 8065);
        chk("trc_ovf", bus_t.dout_ovf, 1);
        tick();

        // Narrowing boundaries, back to back
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(bnd_a[i], bnd_b[i], 1'b1);
            else idle();
            tick();
            if (i >= 2) begin
                chk("bnd_valid", bus.out_valid, 1);
                chk("bnd_sat_dout", $signed(bus.dout), bnd_sat[i-2]);
                chk("bnd_trc_dout", $signed(bus_t.dout), bnd_trc[i-2]);
                chk("bnd_ovf", bus.dout_ovf, bnd_ovf[i-2]);
            end
        end
        tick();
        chk("bnd_drained", bus.out_valid, 0);

        // Accumulation sequence
        drive(10, 3, 1'b0);    tick(); chk("seq_b0_valid", bus.out_valid, 0);
        drive(20, -4, 1'b0);   tick(); chk("seq_b1_valid", bus.out_valid, 0);
        drive(5, 100, 1'b0);   tick(); chk("seq_b2_valid", bus.out_valid, 0);
        drive(1, -1, 1'b1);    tick(); chk("seq_b3_valid", bus.out_valid, 0);
        idle();
        tick();
        chk("seq_wait_valid", bus.out_valid, 0);
        tick();
        chk("seq_valid", bus.out_valid, 1);
        chk("seq_dout", $signed(bus.dout), 449);
        chk("seq_ovf", bus.dout_ovf, 0);
        tick();
        chk("seq_single_result", bus.out_valid, 0);
        drive(7, -2, 1'b1);
        tick();
        idle();
        tick();
        tick();
        chk("seq2_valid", bus.out_valid, 1);
        chk("seq2_dout", $signed(bus.dout), -14);
        tick();

        // Backpressure with a full pipeline
        bus.out_ready = 1'b0;
        drive(1, 1, 1'b1); tick();
        drive(2, 2, 1'b1); tick();
        drive(3, 3, 1'b1); tick();
        chk("bp_valid", bus.out_valid, 1);
        chk("bp_dout", $signed(bus.dout), 1);
        chk("bp_in_ready", bus.in_ready, 0);
        drive(4, 4, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_in_ready", bus.in_ready, 0);
            chk("bp_hold_valid", bus.out_valid, 1);
            chk("bp_hold_dout", $signed(bus.dout), 1);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", bus.in_ready, 1);
        tick();
        idle();
        chk("bp_r2_dout", $signed(bus.dout), 4);
        tick();
        chk("bp_r3_dout", $signed(bus.dout), 9);
        tick();
        chk("bp_r4_valid", bus.out_valid, 1);
        chk("bp_r4_dout", $signed(bus.dout), 16);
        tick();
        chk("bp_drained", bus.out_valid, 0);

        // Asynchronous reset mid-sequence
        drive(50, 2, 1'b0); tick();
        drive(50, 2, 1'b0); tick();
        idle();
        #3 ap_rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_dout", $signed(bus.dout), 0);
        chk("arst_ovf", bus.dout_ovf, 0);
        @(posedge ap_clk);
        #1;
        chk("arst_hold_dout", $signed(bus.dout), 0);
        #3 ap_rst_n = 1'b1;
        tick();
        drive(2, 3, 1'b1);
        tick();
        idle();
        chk("arst_post_valid0", bus.out_valid, 0);
        tick();
        chk("arst_post_valid1", bus.out_valid, 0);
        tick();
        chk("arst_post_valid", bus.out_valid, 1);
        chk("arst_post_dout", $signed(bus.dout), 6);
        tick();

        // Ten back-to-back single-beat products
        for (int i = 0; i < 12; i++) begin
            if (i < 10) drive((i + 1) * 10, (i + 1) - 6, 1'b1);
            else idle();
            tick();
            if (i >= 2) begin
                chk("b2b_valid", bus.out_valid, 1);
                chk("b2b_dout", $signed(bus.dout), (i - 1) * 10 * ((i - 1) - 6));
            end
        end
        tick();
        chk("b2b_drained", bus.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
